// File: rtl/vector_cmd_sequencer_pkg.sv
// rtl/vector_cmd_sequencer_pkg.sv - shared types and helpers for the vector command sequencer
package vec_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_COMPUTE,
    S_LOAD,
    S_SEND,
    S_WAIT_TX
  } state_t;

  localparam int CMD_WRA  = 0;
  localparam int CMD_WRB  = 1;
  localparam int CMD_SUM  = 2;
  localparam int CMD_AVG  = 3;
  localparam int CMD_EUC  = 4;
  localparam int CMD_MAN  = 5;
  localparam int CMD_DOT  = 6;
  localparam int CMD_RSVD = 7;

  function automatic int unsigned tx_bytes(input int unsigned result_w);
    return (result_w + 32'd7) / 32'd8;
  endfunction

  // Vector ops stream the whole result register; reductions produce one word.
  function automatic int unsigned op_word_count(input logic [7:0] cmd, input int unsigned ninputs);
    return (cmd[CMD_SUM] || cmd[CMD_AVG]) ? ninputs : 32'd1;
  endfunction

  function automatic logic cmd_is_valid(input logic [7:0] cmd);
    logic [6:0] ops;
    ops = cmd[6:0];
    return !cmd[CMD_RSVD] && (ops != 7'd0) && ((ops & (ops - 7'd1)) == 7'd0);
  endfunction

endpackage

// File: rtl/vector_cmd_sequencer_if.sv
// rtl/vector_cmd_sequencer_if.sv - host, core, BRAM and UART TX signals of the sequencer
interface vector_cmd_sequencer_if #(
  parameter int RESULT_W = 32
) ();
  logic                command_ready;
  logic [7:0]          command;
  logic                write_done;
  logic                tx_sent;
  logic [RESULT_W-1:0] result_word;
  logic                begin_write;
  logic                write_sel;
  logic [4:0]          enables;
  logic                read_mem_sel;
  logic                load_mem;
  logic                shift_mem;
  logic                begin_transmission;
  logic [7:0]          tx_data;
  logic                busy;
  logic                cmd_error;

  modport master (
    input  command_ready, command, write_done, tx_sent, result_word,
    output begin_write, write_sel, enables, read_mem_sel, load_mem, shift_mem,
           begin_transmission, tx_data, busy, cmd_error
  );

  modport slave (
    output command_ready, command, write_done, tx_sent, result_word,
    input  begin_write, write_sel, enables, read_mem_sel, load_mem, shift_mem,
           begin_transmission, tx_data, busy, cmd_error
  );
endinterface

// File: rtl/vector_cmd_sequencer_word_byte_serializer.sv
// rtl/vector_cmd_sequencer_word_byte_serializer.sv - MSB-first byte slicing of a result word
module word_byte_serializer
  import vec_seq_pkg::*;
#(
  parameter int RESULT_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic                i_capture,
  input  logic                i_advance,
  input  logic [RESULT_W-1:0] i_word,
  output logic [7:0]          o_tx_data,
  output logic                o_last
);
  localparam int TXB = int'(tx_bytes(RESULT_W));
  localparam int KW  = (TXB > 1) ? $clog2(TXB) : 1;

  logic [KW-1:0]      r_k;
  logic [7:0]         r_tx_data;
  logic [TXB*8-1:0]   w_padded;
  logic [KW-1:0]      w_sel;
  logic [KW-1:0]      w_idx;
  logic [7:0]         w_byte;

  assign w_padded = (TXB*8)'(i_word);
  // An advance loads the byte that the incremented index will point at.
  assign w_sel    = i_advance ? (r_k + 1'b1) : r_k;
  assign w_idx    = KW'(TXB - 1) - w_sel;
  assign o_last   = (r_k == KW'(TXB - 1));

  always_comb begin
    w_byte = 8'h00;
    for (int i = 0; i < TXB; i++) begin
      if (w_idx == KW'(i)) w_byte = w_padded[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_k       <= '0;
      r_tx_data <= 8'h00;
    end else begin
      if (i_start)        r_k <= '0;
      else if (i_advance) r_k <= r_k + 1'b1;
      if (i_capture || i_advance) r_tx_data <= w_byte;
    end
  end

  assign o_tx_data = r_tx_data;
endmodule

// File: rtl/vector_cmd_sequencer.sv
// rtl/vector_cmd_sequencer.sv - command decode FSM driving core, BRAM load and UART TX
// Optional handshake watchdog enabled by defining TX_TIMEOUT_EN.
module vector_cmd_sequencer
  import vec_seq_pkg::*;
#(
  parameter int NINPUTS        = 8,
  parameter int RESULT_W       = 32,
  parameter int CORE_LATENCY   = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                    clk,
  input logic                    reset,
  vector_cmd_sequencer_if.master bus
);
  localparam int WW = $clog2(NINPUTS + 1);
  localparam int LW = $clog2(CORE_LATENCY + 1);

  state_t        r_state;
  logic          r_begin_write, r_write_sel, r_read_mem_sel;
  logic          r_load_mem, r_shift_mem, r_begin_tx, r_cmd_error;
  logic [4:0]    r_enables;
  logic [LW-1:0] r_lat_cnt;
  logic [WW-1:0] r_word, r_count;
  logic          w_last_byte, w_ser_start, w_ser_capture, w_ser_advance;
  logic          w_wdog_expired;
  logic [7:0]    w_tx_data;

`ifdef TX_TIMEOUT_EN
  localparam int DW = $clog2(TIMEOUT_CYCLES + 1);
  logic [DW-1:0] r_wdog;

  // Any pass through another state restarts the count, so each entry begins at zero.
  always_ff @(posedge clk) begin
    if (reset) r_wdog <= '0;
    else if (r_state == S_WRITE || r_state == S_WAIT_TX) r_wdog <= r_wdog + 1'b1;
    else r_wdog <= '0;
  end
  assign w_wdog_expired = (r_wdog == DW'(TIMEOUT_CYCLES - 1));
`else
  assign w_wdog_expired = 1'b0;
`endif

  assign w_ser_start   = (r_state == S_COMPUTE) ||
                         (r_state == S_WAIT_TX && bus.tx_sent && w_last_byte);
  assign w_ser_advance = (r_state == S_WAIT_TX) && bus.tx_sent && !w_last_byte;
  // After a shift the SEND state idles one cycle so the core can present the next word.
  assign w_ser_capture = (r_state == S_LOAD) ||
                         (r_state == S_SEND && !r_begin_tx && !r_shift_mem);

  word_byte_serializer #(.RESULT_W(RESULT_W)) u_ser (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_ser_start),
    .i_capture (w_ser_capture),
    .i_advance (w_ser_advance),
    .i_word    (bus.result_word),
    .o_tx_data (w_tx_data),
    .o_last    (w_last_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_begin_write  <= 1'b0;
      r_write_sel    <= 1'b0;
      r_enables      <= 5'd0;
      r_read_mem_sel <= 1'b0;
      r_load_mem     <= 1'b0;
      r_shift_mem    <= 1'b0;
      r_begin_tx     <= 1'b0;
      r_cmd_error    <= 1'b0;
      r_lat_cnt      <= '0;
      r_word         <= '0;
      r_count        <= '0;
    end else begin
      r_begin_write <= 1'b0;
      r_load_mem    <= 1'b0;
      r_shift_mem   <= 1'b0;
      r_begin_tx    <= 1'b0;
      r_cmd_error   <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.command_ready) begin
          if (!cmd_is_valid(bus.command)) begin
            r_cmd_error <= 1'b1;
          end else if (bus.command[CMD_WRA] || bus.command[CMD_WRB]) begin
            r_state       <= S_WRITE;
            r_begin_write <= 1'b1;
            r_write_sel   <= bus.command[CMD_WRB];
          end else begin
            r_state        <= S_COMPUTE;
            r_enables      <= bus.command[CMD_DOT:CMD_SUM];
            r_read_mem_sel <= bus.command[CMD_EUC] | bus.command[CMD_MAN] | bus.command[CMD_DOT];
            r_count        <= WW'(op_word_count(bus.command, NINPUTS));
            r_lat_cnt      <= '0;
          end
        end
        S_WRITE: if (bus.write_done || w_wdog_expired) begin
          r_state     <= S_IDLE;
          r_write_sel <= 1'b0;
          r_cmd_error <= !bus.write_done;
        end
        S_COMPUTE: if (r_lat_cnt == LW'(CORE_LATENCY - 1)) begin
          r_state    <= S_LOAD;
          r_enables  <= 5'd0;
          r_load_mem <= 1'b1;
        end else begin
          r_lat_cnt <= r_lat_cnt + 1'b1;
        end
        S_LOAD: begin
          r_state    <= S_SEND;
          r_begin_tx <= 1'b1;
          r_word     <= '0;
        end
        S_SEND: begin
          if (r_begin_tx)        r_state    <= S_WAIT_TX;
          else if (!r_shift_mem) r_begin_tx <= 1'b1;
        end
        S_WAIT_TX: begin
          if (bus.tx_sent) begin
            if (!w_last_byte) begin
              r_state    <= S_SEND;
              r_begin_tx <= 1'b1;
            end else if (r_word != r_count - 1'b1) begin
              r_state     <= S_SEND;
              r_shift_mem <= 1'b1;
              r_word      <= r_word + 1'b1;
            end else begin
              r_state        <= S_IDLE;
              r_read_mem_sel <= 1'b0;
            end
          end else if (w_wdog_expired) begin
            r_state        <= S_IDLE;
            r_read_mem_sel <= 1'b0;
            r_cmd_error    <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.begin_write        = r_begin_write;
  assign bus.write_sel          = r_write_sel;
  assign bus.enables            = r_enables;
  assign bus.read_mem_sel       = r_read_mem_sel;
  assign bus.load_mem           = r_load_mem;
  assign bus.shift_mem          = r_shift_mem;
  assign bus.begin_transmission = r_begin_tx;
  assign bus.tx_data            = w_tx_data;
  assign bus.busy               = (r_state != S_IDLE);
  assign bus.cmd_error          = r_cmd_error;
endmodule
